// File: rtl/sacc_control.sv
// Multicycle fetch/decode/execute controller for the 16-bit accumulator datapath.
// Strobes are decoded from the state; FETCH/LOAD/STORE completion is qualified by MemReady.
module sacc_control #(
  parameter int OP_WIDTH  = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_CLK,
  input  logic                 i_Reset,
  input  logic [OP_WIDTH-1:0]  i_Opcode,
  input  logic                 i_Zero,
  input  logic                 i_MemReady,
  output logic                 o_IRWrite,
  output logic                 o_RegWrite,
  output logic                 o_AWrite,
  output logic                 o_AccSrc,
  output logic                 o_PCWrite,
  output logic                 o_PCSrc,
  output logic                 o_IorD,
  output logic                 o_MemRead,
  output logic                 o_MemWrite,
  output logic [1:0]           o_ALUOp,
  output logic                 o_Halted,
  output logic                 o_IllegalOp,
  output logic [CNT_WIDTH-1:0] o_InstrCount
);

  localparam logic [OP_WIDTH-1:0] OP_ADD  = OP_WIDTH'('h0);
  localparam logic [OP_WIDTH-1:0] OP_SUB  = OP_WIDTH'('h1);
  localparam logic [OP_WIDTH-1:0] OP_LDA  = OP_WIDTH'('h2);
  localparam logic [OP_WIDTH-1:0] OP_STA  = OP_WIDTH'('h3);
  localparam logic [OP_WIDTH-1:0] OP_BEQZ = OP_WIDTH'('h4);
  localparam logic [OP_WIDTH-1:0] OP_JMP  = OP_WIDTH'('h5);
  localparam logic [OP_WIDTH-1:0] OP_HALT = OP_WIDTH'('hE);
  localparam logic [OP_WIDTH-1:0] OP_SACC = OP_WIDTH'('hF);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_ALU, S_LOAD, S_STORE, S_BRANCH, S_SACC, S_HALT
  } state_t;

  typedef struct packed {
    logic       ir_write;
    logic       reg_write;
    logic       a_write;
    logic       acc_src;
    logic       pc_write;
    logic       pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] alu_op;
    logic       halted;
    logic       illegal;
  } ctl_t;

  state_t                 r_state;
  logic [CNT_WIDTH-1:0]   r_count;
  // Opcode is only valid in DECODE, so the execute states use these latched flavours.
  logic                   r_sub;
  logic                   r_jmp;
  logic                   w_legal;
  ctl_t                   w_ctl;

  always_comb begin
    w_legal = (i_Opcode == OP_ADD)  || (i_Opcode == OP_SUB)  ||
              (i_Opcode == OP_LDA)  || (i_Opcode == OP_STA)  ||
              (i_Opcode == OP_BEQZ) || (i_Opcode == OP_JMP)  ||
              (i_Opcode == OP_HALT) || (i_Opcode == OP_SACC);
  end

  always_ff @(posedge i_CLK or posedge i_Reset) begin
    if (i_Reset) begin
      r_state <= S_FETCH;
      r_count <= '0;
      r_sub   <= 1'b0;
      r_jmp   <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: if (i_MemReady) begin
          r_count <= r_count + CNT_WIDTH'(1);
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_sub <= (i_Opcode == OP_SUB);
          r_jmp <= (i_Opcode == OP_JMP);
          if      (i_Opcode == OP_ADD || i_Opcode == OP_SUB)  r_state <= S_ALU;
          else if (i_Opcode == OP_LDA)                        r_state <= S_LOAD;
          else if (i_Opcode == OP_STA)                        r_state <= S_STORE;
          else if (i_Opcode == OP_BEQZ || i_Opcode == OP_JMP) r_state <= S_BRANCH;
          else if (i_Opcode == OP_SACC)                       r_state <= S_SACC;
          else if (i_Opcode == OP_HALT)                       r_state <= S_HALT;
          else                                                r_state <= S_FETCH;
        end
        S_ALU, S_BRANCH, S_SACC: r_state <= S_FETCH;
        S_LOAD, S_STORE: if (i_MemReady) r_state <= S_FETCH;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    w_ctl = '0;
    case (r_state)
      S_FETCH: begin
        w_ctl.mem_read = 1'b1;
        w_ctl.ir_write = i_MemReady;
        w_ctl.pc_write = i_MemReady;
      end
      S_DECODE: w_ctl.illegal = ~w_legal;
      S_ALU: begin
        w_ctl.a_write = 1'b1;
        w_ctl.alu_op  = r_sub ? 2'b01 : 2'b00;
      end
      S_LOAD: begin
        w_ctl.mem_read = 1'b1;
        w_ctl.iord     = 1'b1;
        w_ctl.a_write  = i_MemReady;
        w_ctl.acc_src  = i_MemReady;
      end
      S_STORE: begin
        w_ctl.mem_write = 1'b1;
        w_ctl.iord      = 1'b1;
      end
      S_BRANCH: begin
        w_ctl.pc_src   = 1'b1;
        w_ctl.alu_op   = 2'b10;
        w_ctl.pc_write = r_jmp | i_Zero;
      end
      S_SACC:  w_ctl.reg_write = 1'b1;
      S_HALT:  w_ctl.halted    = 1'b1;
      default: w_ctl = '0;
    endcase
    // Reset must silence the bus immediately, before the FETCH decode re-asserts MemRead.
    if (i_Reset) w_ctl = '0;
  end

  assign o_IRWrite    = w_ctl.ir_write;
  assign o_RegWrite   = w_ctl.reg_write;
  assign o_AWrite     = w_ctl.a_write;
  assign o_AccSrc     = w_ctl.acc_src;
  assign o_PCWrite    = w_ctl.pc_write;
  assign o_PCSrc      = w_ctl.pc_src;
  assign o_IorD       = w_ctl.iord;
  assign o_MemRead    = w_ctl.mem_read;
  assign o_MemWrite   = w_ctl.mem_write;
  assign o_ALUOp      = w_ctl.alu_op;
  assign o_Halted     = w_ctl.halted;
  assign o_IllegalOp  = w_ctl.illegal;
  assign o_InstrCount = r_count;

endmodule

// File: tb/tb_sacc_control.sv
// Directed cycle-by-cycle vectors for sacc_control; a 2-bit-counter instance covers wrap.
module tb_sacc_control;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  op  = '0;
  logic        zero = 1'b0;
  logic        mr  = 1'b1;

  logic        irw, rgw, aw, accs, pcw, pcs, iord, mrd, mwr, hlt, ill;
  logic [1:0]  aluop;
  logic [15:0] cnt;

  logic        d2_irw, d2_rgw, d2_aw, d2_accs, d2_pcw, d2_pcs, d2_iord, d2_mrd, d2_mwr, d2_hlt, d2_ill;
  logic [1:0]  d2_aluop;
  logic [1:0]  d2_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sacc_control dut (
    .i_CLK(clk), .i_Reset(rst), .i_Opcode(op), .i_Zero(zero), .i_MemReady(mr),
    .o_IRWrite(irw), .o_RegWrite(rgw), .o_AWrite(aw), .o_AccSrc(accs),
    .o_PCWrite(pcw), .o_PCSrc(pcs), .o_IorD(iord), .o_MemRead(mrd),
    .o_MemWrite(mwr), .o_ALUOp(aluop), .o_Halted(hlt), .o_IllegalOp(ill),
    .o_InstrCount(cnt)
  );

  sacc_control #(.OP_WIDTH(4), .CNT_WIDTH(2)) dut2 (
    .i_CLK(clk), .i_Reset(rst), .i_Opcode(op), .i_Zero(zero), .i_MemReady(mr),
    .o_IRWrite(d2_irw), .o_RegWrite(d2_rgw), .o_AWrite(d2_aw), .o_AccSrc(d2_accs),
    .o_PCWrite(d2_pcw), .o_PCSrc(d2_pcs), .o_IorD(d2_iord), .o_MemRead(d2_mrd),
    .o_MemWrite(d2_mwr), .o_ALUOp(d2_aluop), .o_Halted(d2_hlt), .o_IllegalOp(d2_ill),
    .o_InstrCount(d2_cnt)
  );

  // {IRWrite,RegWrite,AWrite,AccSrc,PCWrite,PCSrc,IorD,MemRead,MemWrite,ALUOp[1:0],Halted,IllegalOp}
  localparam logic [12:0] E_ZERO  = 13'b0_0_0_0_0_0_0_0_0_00_0_0;
  localparam logic [12:0] E_FWAIT = 13'b0_0_0_0_0_0_0_1_0_00_0_0;
  localparam logic [12:0] E_FGO   = 13'b1_0_0_0_1_0_0_1_0_00_0_0;
  localparam logic [12:0] E_ILL   = 13'b0_0_0_0_0_0_0_0_0_00_0_1;
  localparam logic [12:0] E_ADD   = 13'b0_0_1_0_0_0_0_0_0_00_0_0;
  localparam logic [12:0] E_SUB   = 13'b0_0_1_0_0_0_0_0_0_01_0_0;
  localparam logic [12:0] E_LWAIT = 13'b0_0_0_0_0_0_1_1_0_00_0_0;
  localparam logic [12:0] E_LGO   = 13'b0_0_1_1_0_0_1_1_0_00_0_0;
  localparam logic [12:0] E_STORE = 13'b0_0_0_0_0_0_1_0_1_00_0_0;
  localparam logic [12:0] E_BRNT  = 13'b0_0_0_0_0_1_0_0_0_10_0_0;
  localparam logic [12:0] E_BRT   = 13'b0_0_0_0_1_1_0_0_0_10_0_0;
  localparam logic [12:0] E_SACC  = 13'b0_1_0_0_0_0_0_0_0_00_0_0;
  localparam logic [12:0] E_HALT  = 13'b0_0_0_0_0_0_0_0_0_00_1_0;

  typedef struct {
    logic        rst;
    logic [3:0]  op;
    logic        zero;
    logic        mr;
    logic [12:0] exp;
    logic [15:0] cnt;
    string       tag;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic r, input logic [3:0] o, input logic z,
                              input logic m, input logic [12:0] e, input logic [15:0] c,
                              input string t);
    vec_t v;
    v.rst = r; v.op = o; v.zero = z; v.mr = m; v.exp = e; v.cnt = c; v.tag = t;
    vq.push_back(v);
  endfunction

  // Drive at the falling edge, look 1 time unit later, before the next rising edge.
  task automatic step(input vec_t v);
    logic [12:0] got;
    @(negedge clk);
    rst = v.rst; op = v.op; zero = v.zero; mr = v.mr;
    #1;
    got = {irw, rgw, aw, accs, pcw, pcs, iord, mrd, mwr, aluop, hlt, ill};
    checks++;
    if (got !== v.exp) begin
      errors++;
      $display("FAIL %s strobes: got %b expected %b", v.tag, got, v.exp);
    end
    checks++;
    if (cnt !== v.cnt) begin
      errors++;
      $display("FAIL %s InstrCount: got %0d expected %0d", v.tag, cnt, v.cnt);
    end
    checks++;
    if (d2_cnt !== v.cnt[1:0]) begin
      errors++;
      $display("FAIL %s wrap-counter: got %0d expected %0d", v.tag, d2_cnt, v.cnt[1:0]);
    end
  endtask

  initial begin
    // reset state
    add(1, 4'h9, 0, 1, E_ZERO,  0, "reset0");
    add(1, 4'h0, 0, 1, E_ZERO,  0, "reset1");
    // SACC (FETCH opcode is junk, ignored)
    add(0, 4'h9, 0, 1, E_FGO,   0, "sacc_fetch");
    add(0, 4'hF, 0, 1, E_ZERO,  1, "sacc_decode");
    add(0, 4'h9, 0, 1, E_SACC,  1, "sacc_exec");
    // ADD then SUB; opcode changed in execute must be ignored
    add(0, 4'h2, 0, 1, E_FGO,   1, "add_fetch");
    add(0, 4'h0, 0, 1, E_ZERO,  2, "add_decode");
    add(0, 4'h1, 0, 1, E_ADD,   2, "add_exec");
    add(0, 4'h0, 0, 1, E_FGO,   2, "sub_fetch");
    add(0, 4'h1, 0, 1, E_ZERO,  3, "sub_decode");
    add(0, 4'h0, 0, 1, E_SUB,   3, "sub_exec");
    add(1, 4'h0, 0, 1, E_ZERO,  0, "reset2");
    // LDA with 2 fetch waits and 3 load waits: 8 cycles
    add(0, 4'h2, 0, 0, E_FWAIT, 0, "lda_fwait0");
    add(0, 4'h2, 0, 0, E_FWAIT, 0, "lda_fwait1");
    add(0, 4'h2, 0, 1, E_FGO,   0, "lda_fetch");
    add(0, 4'h2, 0, 0, E_ZERO,  1, "lda_decode");
    add(0, 4'h2, 0, 0, E_LWAIT, 1, "lda_lwait0");
    add(0, 4'h2, 0, 0, E_LWAIT, 1, "lda_lwait1");
    add(0, 4'h2, 0, 0, E_LWAIT, 1, "lda_lwait2");
    add(0, 4'h2, 0, 1, E_LGO,   1, "lda_load");
    // STA with one wait; MemWrite drops after MemReady
    add(0, 4'h3, 0, 1, E_FGO,   1, "sta_fetch");
    add(0, 4'h3, 0, 1, E_ZERO,  2, "sta_decode");
    add(0, 4'h3, 0, 0, E_STORE, 2, "sta_wait");
    add(0, 4'h3, 0, 1, E_STORE, 2, "sta_store");
    add(0, 4'h3, 0, 0, E_FWAIT, 2, "sta_after");
    // BEQZ not taken (Zero high in DECODE must be ignored), BEQZ taken, JMP with Zero=0
    add(0, 4'h4, 1, 1, E_FGO,   2, "beqz0_fetch");
    add(0, 4'h4, 1, 1, E_ZERO,  3, "beqz0_decode");
    add(0, 4'h4, 0, 1, E_BRNT,  3, "beqz0_branch");
    add(0, 4'h4, 0, 1, E_FGO,   3, "beqz1_fetch");
    add(0, 4'h4, 0, 1, E_ZERO,  4, "beqz1_decode");
    add(0, 4'h4, 1, 1, E_BRT,   4, "beqz1_branch");
    add(0, 4'h5, 0, 1, E_FGO,   4, "jmp_fetch");
    add(0, 4'h5, 0, 1, E_ZERO,  5, "jmp_decode");
    add(0, 4'h5, 0, 1, E_BRT,   5, "jmp_branch");
    // reset mid-LOAD
    add(0, 4'h2, 0, 1, E_FGO,   5, "rl_fetch");
    add(0, 4'h2, 0, 1, E_ZERO,  6, "rl_decode");
    add(0, 4'h2, 0, 0, E_LWAIT, 6, "rl_lwait");
    add(1, 4'h2, 0, 0, E_ZERO,  0, "rl_reset");
    add(0, 4'h2, 0, 0, E_FWAIT, 0, "rl_release");
    // reset mid-STORE
    add(0, 4'h3, 0, 1, E_FGO,   0, "rs_fetch");
    add(0, 4'h3, 0, 1, E_ZERO,  1, "rs_decode");
    add(0, 4'h3, 0, 0, E_STORE, 1, "rs_swait");
    add(1, 4'h3, 0, 0, E_ZERO,  0, "rs_reset");
    add(0, 4'h3, 0, 1, E_FGO,   0, "rs_release");
    // illegal 0x9 then HALT
    add(0, 4'h9, 0, 1, E_ILL,   1, "ill_decode");
    add(0, 4'hE, 0, 1, E_FGO,   1, "halt_fetch");
    add(0, 4'hE, 0, 1, E_ZERO,  2, "halt_decode");

    for (int i = 0; i < vq.size(); i++) step(vq[i]);

    // HALT holds for 20 cycles whatever the inputs do
    for (int i = 0; i < 20; i++) begin
      vec_t v;
      v.rst = 0; v.op = 4'(i); v.zero = i[0]; v.mr = ~i[1];
      v.exp = E_HALT; v.cnt = 2; v.tag = "halt_hold";
      step(v);
    end

    // only Reset leaves HALT; the first cycle after release fetches
    begin
      vec_t v;
      v.rst = 1; v.op = 4'h0; v.zero = 0; v.mr = 1; v.exp = E_ZERO; v.cnt = 0; v.tag = "halt_reset";
      step(v);
      v.rst = 0; v.exp = E_FGO; v.tag = "halt_release";
      step(v);
      v.exp = E_ZERO; v.cnt = 1; v.tag = "post_halt_decode";
      step(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sacc_control.md
# sacc_control

Multicycle control unit that sequences the 16-bit accumulator (sacc) datapath. Reads the opcode from the instruction register and drives the datapath strobes (IRWrite, RegWrite, AWrite, PC, memory, and ALU selects) through a fetch/decode/execute state machine. Stalls on a memory-ready handshake and keeps a retired-instruction counter for debug.

## Interface
- OP_WIDTH, 4, opcode width; the opcode is IR[15:12].
- CNT_WIDTH, 16, width of the retired-instruction counter.
- CLK  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Opcode  in  OP_WIDTH  IR[15:12] from the datapath instruction register.
- Zero  in  1  accumulator-equals-zero flag from the datapath.
- MemReady  in  1  memory has completed the current read or write this cycle.
- IRWrite  out  1  load the instruction register.
- RegWrite  out  1  write the accumulator into the register file.
- AWrite  out  1  load the accumulator.
- AccSrc  out  1  accumulator input select: 0 = ALU, 1 = memory data.
- PCWrite  out  1  load the PC.
- PCSrc  out  1  PC input select: 0 = PC+2, 1 = branch target.
- IorD  out  1  memory address select: 0 = PC, 1 = IR address field.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- ALUOp  out  2  ALU operation: 00 = add, 01 = sub, 10 = pass B.
- Halted  out  1  the controller is in HALT.
- IllegalOp  out  1  one-cycle pulse on an undefined opcode.
- InstrCount  out  CNT_WIDTH  number of fetched instructions.

## Operation
- Opcodes:
  - 0x0 ADD: A <= A + R.
  - 0x1 SUB: A <= A - R.
  - 0x2 LDA: A <= M[addr].
  - 0x3 STA: M[addr] <= A.
  - 0x4 BEQZ: branch if Zero.
  - 0x5 JMP: unconditional branch.
  - 0xE HALT.
  - 0xF SACC: R[n] <= A.
  - Any other opcode is illegal.
- States are FETCH, DECODE, ALU, LOAD, STORE, BRANCH, SACC, HALT. Outputs are Moore-decoded from the state, except that the FETCH, LOAD and STORE completion strobes are qualified by MemReady.
- FETCH: MemRead=1, IorD=0.
  - When MemReady=1: IRWrite=1, PCWrite=1, PCSrc=0, InstrCount+1, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: all strobes 0. The next state follows the opcode:
  - ADD/SUB -> ALU; LDA -> LOAD; STA -> STORE; BEQZ/JMP -> BRANCH; SACC -> SACC; HALT -> HALT.
  - Illegal opcode -> FETCH, with IllegalOp=1 for this cycle.
- ALU: AWrite=1, AccSrc=0, ALUOp=00 (ADD) or 01 (SUB), then go to FETCH.
- LOAD: MemRead=1, IorD=1.
  - When MemReady=1: AWrite=1, AccSrc=1, then go to FETCH.
  - Otherwise hold with AWrite=0.
- STORE: MemWrite=1, IorD=1, held until MemReady=1, then go to FETCH.
- BRANCH: PCSrc=1, ALUOp=10; PCWrite = Zero for BEQZ and 1 for JMP. Then go to FETCH.
- SACC: RegWrite=1 for exactly one cycle, then go to FETCH.
- HALT: Halted=1 and all strobes 0. Only Reset leaves HALT.
- InstrCount is unsigned and wraps from all-ones to 0.

## Timing
- Reset asserted, at any time and in any state: the state is FETCH immediately, InstrCount=0, Halted=0, IllegalOp=0. Every strobe, including MemRead, is forced to 0 while Reset=1.
- First cycle after Reset is released: MemRead=1, IorD=0.
- Cycle counts with zero-wait memory (MemReady tied high):
  - ADD, SUB, BEQZ, JMP, SACC: 3 cycles each.
  - LDA, STA: 3 cycles each.
  - Illegal opcode: 2 cycles.
- Each cycle with MemReady=0 in FETCH, LOAD or STORE adds exactly one cycle.
- MemRead and MemWrite are never both 1. They stay stable while waiting and drop in the cycle after MemReady.
- Opcode is sampled only in DECODE; changes to Opcode in any other state are ignored.
- Zero is sampled only in BRANCH.
- RegWrite, AWrite, PCWrite and IRWrite are never asserted in the same cycle as each other, except that IRWrite and PCWrite assert together in FETCH.

## Test plan
- SACC with MemReady=1, Opcode=0xF: IRWrite=1 in cycle 1, RegWrite=1 only in cycle 3, back in FETCH in cycle 4, InstrCount=1.
- ADD then SUB: AWrite=1 with ALUOp=00 in cycle 3, then AWrite=1 with ALUOp=01 in cycle 6; InstrCount=2.
- LDA with MemReady low for 2 cycles in FETCH and 3 cycles in LOAD: total 8 cycles; MemRead held throughout; AWrite=1 and AccSrc=1 only in the MemReady cycle.
- BEQZ with Zero=0, then Zero=1: PCWrite=0 in the first BRANCH cycle; PCWrite=1 with PCSrc=1 in the second.
- Opcode=0x9, then HALT: IllegalOp pulses once and the controller returns to FETCH. After HALT, Halted stays 1 for 20 cycles and InstrCount freezes at 2.
- Reset asserted mid-LOAD and mid-STORE: all strobes go to 0 immediately and InstrCount=0. After release, MemRead=1 and IorD=0 on the next cycle.
